// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and datapath widths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CNT_W     = 17;
  localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX pin; resets to the idle-high line level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8/N/1 LSB first: centre-sampling FSM feeding a single-entry valid/ready buffer
// with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx,
  input  logic [15:0]               i_divider,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
  output logic                      o_overrun,
  output logic                      o_busy
);

  logic                      w_rxs;
  rx_state_t                 r_state, w_state_d;
  logic [UART_CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [15:0]               r_div, w_div_d;
  logic [UART_IDX_W-1:0]     r_bit_idx, w_bit_idx_d;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_d;
  logic                      w_commit, w_frame_err;
  logic [15:0]               w_div_in;
  logic [UART_CNT_W-1:0]     w_bit_reload;
  logic [UART_CNT_W-1:0]     w_cnt_dec;

  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid, r_frame_err, r_overrun;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (w_rxs)
  );

  // A zero divider would stall the counter; treat it as the fastest legal rate.
  assign w_div_in     = (i_divider == 16'd0) ? 16'd1 : i_divider;
  assign w_bit_reload = {r_div, 1'b0} - UART_CNT_W'(1);
  assign w_cnt_dec    = r_cnt - UART_CNT_W'(1);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_div_d     = r_div;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_commit    = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state_d = START;
          w_div_d   = w_div_in;
          w_cnt_d   = {1'b0, w_div_in} - UART_CNT_W'(1);
        end
      end
      START: begin
        if (r_cnt == '0) begin
          if (w_rxs) begin
            w_state_d = IDLE;
          end else begin
            w_state_d   = DATA;
            w_bit_idx_d = '0;
            w_cnt_d     = w_bit_reload;
          end
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      DATA: begin
        if (r_cnt == '0) begin
          w_shift_d[r_bit_idx] = w_rxs;
          w_cnt_d              = w_bit_reload;
          if (r_bit_idx == UART_IDX_W'(UART_DATA_BITS - 1)) begin
            w_state_d = STOP;
          end else begin
            w_bit_idx_d = r_bit_idx + UART_IDX_W'(1);
          end
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is caught.
        if (r_cnt == '0) begin
          if (w_rxs) begin
            w_commit  = 1'b1;
            w_state_d = IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_d   = BREAK;
          end
        end else begin
          w_cnt_d = w_cnt_dec;
        end
      end
      BREAK: begin
        if (w_rxs) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div     <= 16'd1;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_div     <= w_div_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
    end
  end

  // Single-entry output buffer; a held byte is never overwritten, the new one is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_commit && r_valid && !i_ready;
      if (w_commit && (!r_valid || i_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-accurate line driver, event counters sampled on the falling edge.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        ready = 1'b0;
  logic [15:0] divider = 16'd4;
  logic [7:0]  data;
  logic        valid, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  int       fe_cnt = 0, ov_cnt = 0, both_cnt = 0, acc_cnt = 0, rise_cnt = 0;
  int       valid_cycles = 0, hold_viol = 0;
  logic [7:0] acc_last = 8'h00;
  logic       prev_valid = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(
    .SYNC_STAGES(2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .i_divider  (divider),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .o_busy     (busy)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
    if (valid === 1'b1 && ready === 1'b1) begin
      acc_cnt++;
      acc_last = data;
    end
    if (valid === 1'b1 && prev_valid !== 1'b1) rise_cnt++;
    if (valid === 1'b1) valid_cycles++;
    if (prev_hold && (valid !== 1'b1 || data !== prev_data)) hold_viol++;
    prev_hold  = (valid === 1'b1 && ready === 1'b0 && rst === 1'b0);
    prev_data  = data;
    prev_valid = valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input int div);
    int n;
    n  = (div == 0) ? 2 : 2 * div;
    rx = 1'b0;
    tick(n);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      tick(n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
    send_partial(b, 8, div);
    rx = stop;
    tick((div == 0) ? 2 : 2 * div);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    int fe0, ov0, acc0, rise0, vc0;
    fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt; rise0 = rise_cnt; vc0 = valid_cycles;
    ready = 1'b1;
    send_byte(8'hA5, 1'b1, 4);
    tick(6);
    checks++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL single_acc got %0d exp 1", acc_cnt - acc0); end
    checks++; if (acc_last !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", acc_last); end
    checks++; if (valid_cycles - vc0 !== 1) begin errors++; $display("FAIL single_vcyc got %0d exp 1", valid_cycles - vc0); end
    checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin errors++; $display("FAIL single_flags got %0d exp 0", fe_cnt - fe0 + ov_cnt - ov0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    checks++; if (rise_cnt - rise0 !== 1) begin errors++; $display("FAIL single_rise got %0d exp 1", rise_cnt - rise0); end
  endtask

  task automatic test_back_to_back();
    int ov0, rise0, hv0, fe0;
    ov0 = ov_cnt; rise0 = rise_cnt; hv0 = hold_viol; fe0 = fe_cnt;
    ready = 1'b0;
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'hFF, 1'b1, 4);
    send_byte(8'h3C, 1'b1, 4);
    tick(6);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL b2b_data got %h exp 00", data); end
    checks++; if (ov_cnt - ov0 !== 2) begin errors++; $display("FAIL b2b_overrun got %0d exp 2", ov_cnt - ov0); end
    checks++; if (rise_cnt - rise0 !== 1) begin errors++; $display("FAIL b2b_rise got %0d exp 1", rise_cnt - rise0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL b2b_fe got %0d exp 0", fe_cnt - fe0); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %b exp 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL b2b_drain_data got %h exp 00", data); end
    checks++; if (acc_last !== 8'h00) begin errors++; $display("FAIL b2b_acc got %h exp 00", acc_last); end
    checks++; if (hold_viol - hv0 !== 0) begin errors++; $display("FAIL b2b_hold got %0d exp 0", hold_viol - hv0); end
  endtask

  task automatic test_frame_error();
    int fe0, rise0, ov0;
    fe0 = fe_cnt; rise0 = rise_cnt; ov0 = ov_cnt;
    ready = 1'b1;
    send_byte(8'h55, 1'b0, 4);
    tick(40);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL fe_count got %0d exp 1", fe_cnt - fe0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_break_busy got %b exp 1", busy); end
    checks++; if (rise_cnt - rise0 !== 0) begin errors++; $display("FAIL fe_novalid got %0d exp 0", rise_cnt - rise0); end
    rx = 1'b1;
    tick(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_idle_busy got %b exp 0", busy); end
    send_byte(8'h12, 1'b1, 4);
    tick(6);
    checks++; if (rise_cnt - rise0 !== 1) begin errors++; $display("FAIL fe_next_rise got %0d exp 1", rise_cnt - rise0); end
    checks++; if (acc_last !== 8'h12) begin errors++; $display("FAIL fe_next_data got %h exp 12", acc_last); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL fe_total got %0d exp 1", fe_cnt - fe0); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL fe_ov got %0d exp 0", ov_cnt - ov0); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL fe_ov_together got %0d exp 0", both_cnt); end
  endtask

  task automatic test_glitch();
    int fe0, ov0, rise0;
    fe0 = fe_cnt; ov0 = ov_cnt; rise0 = rise_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy got %b exp 1", busy); end
    tick(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b exp 0", busy); end
    checks++; if (rise_cnt - rise0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", rise_cnt - rise0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_fe got %0d exp 0", fe_cnt - fe0); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL glitch_ov got %0d exp 0", ov_cnt - ov0); end
  endtask

  task automatic test_commit_with_accept();
    int ov0, acc0, rise0, hv0;
    ov0 = ov_cnt; acc0 = acc_cnt; rise0 = rise_cnt; hv0 = hold_viol;
    ready = 1'b0;
    send_byte(8'h11, 1'b1, 4);
    // Stop-bit decision for the next frame lands 79 clocks after its start bit is driven.
    fork
      send_byte(8'h22, 1'b1, 4);
      begin
        tick(78);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(2);
    checks++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL cwa_acc got %0d exp 1", acc_cnt - acc0); end
    checks++; if (acc_last !== 8'h11) begin errors++; $display("FAIL cwa_acc_data got %h exp 11", acc_last); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL cwa_valid got %b exp 1", valid); end
    checks++; if (data !== 8'h22) begin errors++; $display("FAIL cwa_data got %h exp 22", data); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL cwa_ov got %0d exp 0", ov_cnt - ov0); end
    checks++; if (rise_cnt - rise0 !== 1) begin errors++; $display("FAIL cwa_rise got %0d exp 1", rise_cnt - rise0); end
    checks++; if (hold_viol - hv0 !== 0) begin errors++; $display("FAIL cwa_hold got %0d exp 0", hold_viol - hv0); end
  endtask

  task automatic test_reset_midframe_and_div();
    int fe0, ov0, acc0;
    ready = 1'b0;
    send_partial(8'h99, 4, 4);
    rx = 1'b1;  // bit 4 of 0x99
    tick(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b exp 1", busy); end
    fe0 = fe_cnt; ov0 = ov_cnt;
    rst = 1'b1;
    tick(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_after got %b exp 0", busy); end
    rst = 1'b0;
    tick(20);
    checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin errors++; $display("FAIL rst_mid_flags got %0d exp 0", fe_cnt - fe0 + ov_cnt - ov0); end
    ready = 1'b1;
    acc0 = acc_cnt;
    send_byte(8'h7E, 1'b1, 4);
    tick(6);
    checks++; if (acc_last !== 8'h7E) begin errors++; $display("FAIL post_rst_data got %h exp 7e", acc_last); end
    checks++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL post_rst_acc got %0d exp 1", acc_cnt - acc0); end
    divider  = 16'd1;
    acc_last = 8'h00;
    send_byte(8'hC3, 1'b1, 1);
    tick(6);
    checks++; if (acc_last !== 8'hC3) begin errors++; $display("FAIL div1_data got %h exp c3", acc_last); end
    divider  = 16'd0;
    acc_last = 8'h00;
    send_byte(8'hC3, 1'b1, 0);
    tick(6);
    checks++; if (acc_last !== 8'hC3) begin errors++; $display("FAIL div0_data got %h exp c3", acc_last); end
    checks++; if (acc_cnt - acc0 !== 3) begin errors++; $display("FAIL div_acc got %0d exp 3", acc_cnt - acc0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_commit_with_accept();
    test_reset_midframe_and_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
